// File: rtl/rgb_fx_pkg.sv
// rtl/rgb_fx_pkg.sv - shared encodings for the RGB animation PWM block
// Contents: animation mode codes carried on cfg_mode/cur_mode, colour wheel sector indices.
package rgb_fx_pkg;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_STATIC  = 3'd1;
  localparam logic [2:0] MODE_HUE     = 3'd2;
  localparam logic [2:0] MODE_BREATHE = 3'd3;
  localparam logic [2:0] MODE_BLINK   = 3'd4;

  // Colour wheel sectors, named by the transition each one sweeps through.
  localparam logic [2:0] SEC_R_Y = 3'd0;
  localparam logic [2:0] SEC_Y_G = 3'd1;
  localparam logic [2:0] SEC_G_C = 3'd2;
  localparam logic [2:0] SEC_C_B = 3'd3;
  localparam logic [2:0] SEC_B_M = 3'd4;
  localparam logic [2:0] SEC_M_R = 3'd5;

endpackage

// File: rtl/rgb_fx_hue2rgb.sv
// rtl/rgb_fx_hue2rgb.sv - combinational hue to raw {r,g,b} colour wheel map
// Ports: hue  in  W+3  hue position, sector in hue[W+2:W], ramp in hue[W-1:0]
//        rgb  out 3*W  raw {r,g,b} at full scale, r in the top W bits
module rgb_fx_hue2rgb
  import rgb_fx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W+2:0]   hue,
  output logic [3*W-1:0] rgb
);

  localparam logic [W-1:0] FULL = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [2:0]   sector;
  logic [W-1:0] ramp;

  assign sector = hue[W+2:W];
  assign ramp   = hue[W-1:0];

  always_comb begin
    rgb = '0;
    case (sector)
      SEC_R_Y: rgb = {FULL, ramp, ZERO};
      SEC_Y_G: rgb = {FULL - ramp, FULL, ZERO};
      SEC_G_C: rgb = {ZERO, FULL, ramp};
      SEC_C_B: rgb = {ZERO, FULL - ramp, FULL};
      SEC_B_M: rgb = {ramp, ZERO, FULL};
      SEC_M_R: rgb = {FULL, ZERO, FULL - ramp};
      default: rgb = '0;
    endcase
  end

endmodule

// File: rtl/rgb_fx_pwm.sv
// rtl/rgb_fx_pwm.sv - RGB LED PWM driver with off/static/hue/breathe/blink animation
// Ports: clk, rst (sync, active high)
//        cfg_valid/cfg_ready      configuration handshake
//        cfg_mode/color/bright/rate  configuration fields, captured on transfer
//        pwm_out {r,g,b}          PWM to LED driver
//        frame_strobe             last cycle of each 2^W-cycle PWM frame
//        cur_mode                 mode currently applied
module rgb_fx_pwm
  import rgb_fx_pkg::*;
#(
  parameter int W         = 8,
  parameter int RATE_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2:0]           cfg_mode,
  input  logic [3*W-1:0]       cfg_color,
  input  logic [W-1:0]         cfg_bright,
  input  logic [RATE_BITS-1:0] cfg_rate,
  output logic [2:0]           pwm_out,
  output logic                 frame_strobe,
  output logic [2:0]           cur_mode
);

  localparam int            HW       = W + 3;
  localparam int            PW       = 2 * W;
  localparam logic [HW-1:0] HUE_MAX  = HW'(6 * (2 ** W) - 1);
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};

  logic [W-1:0]         cnt;
  logic                 pend_valid;
  logic [2:0]           p_mode;
  logic [3*W-1:0]       p_color, a_color;
  logic [W-1:0]         p_bright, a_bright;
  logic [RATE_BITS-1:0] p_rate, a_rate, pre;
  logic [HW-1:0]        hue;
  logic [W-1:0]         env;
  logic                 env_down;
  logic                 blink_on;
  logic [3*W-1:0]       hue_rgb, raw;
  logic [W-1:0]         bright_eff;
  logic [W-1:0]         level_r, level_g, level_b;
  logic [W-1:0]         shadow_r, shadow_g, shadow_b;
  logic                 accept, apply, tick;

  // (v * (b + 1)) >> W never exceeds W bits, so full scale maps to full scale.
  function automatic logic [W-1:0] scale(input logic [W-1:0] v, input logic [W-1:0] b);
    logic [PW-1:0] prod;
    prod = {{W{1'b0}}, v} * ({{W{1'b0}}, b} + PW'(1));
    return W'(prod >> W);
  endfunction

  assign frame_strobe = (cnt == ALL_ONES);
  assign cfg_ready    = ~pend_valid;
  assign accept       = cfg_valid & cfg_ready;
  // accept needs an empty pending slot and apply a full one, so they never coincide.
  assign apply        = frame_strobe & pend_valid;
  assign tick         = (pre == a_rate);

  // All-ones duty must be a true 100%, which cnt < shadow alone cannot reach.
  assign pwm_out[2] = (shadow_r == ALL_ONES) || (cnt < shadow_r);
  assign pwm_out[1] = (shadow_g == ALL_ONES) || (cnt < shadow_g);
  assign pwm_out[0] = (shadow_b == ALL_ONES) || (cnt < shadow_b);

  rgb_fx_hue2rgb #(.W(W)) u_hue2rgb (
    .hue (hue),
    .rgb (hue_rgb)
  );

  // Reserved modes fall through to the default and stay dark.
  always_comb begin
    raw        = '0;
    bright_eff = a_bright;
    case (cur_mode)
      MODE_STATIC:  raw = a_color;
      MODE_HUE:     raw = hue_rgb;
      MODE_BREATHE: begin
        raw        = a_color;
        bright_eff = scale(env, a_bright);
      end
      MODE_BLINK:   raw = blink_on ? a_color : '0;
      default:      raw = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      pend_valid <= 1'b0;
      p_mode     <= MODE_OFF;
      p_color    <= '0;
      p_bright   <= '0;
      p_rate     <= '0;
      cur_mode   <= MODE_OFF;
      a_color    <= '0;
      a_bright   <= '0;
      a_rate     <= '0;
      pre        <= '0;
      hue        <= '0;
      env        <= '0;
      env_down   <= 1'b0;
      blink_on   <= 1'b1;
      level_r    <= '0;
      level_g    <= '0;
      level_b    <= '0;
      shadow_r   <= '0;
      shadow_g   <= '0;
      shadow_b   <= '0;
    end else begin
      cnt     <= cnt + W'(1);
      level_r <= scale(raw[3*W-1:2*W], bright_eff);
      level_g <= scale(raw[2*W-1:W], bright_eff);
      level_b <= scale(raw[W-1:0], bright_eff);

      if (frame_strobe) begin
        shadow_r <= level_r;
        shadow_g <= level_g;
        shadow_b <= level_b;
      end

      if (accept) begin
        pend_valid <= 1'b1;
        p_mode     <= cfg_mode;
        p_color    <= cfg_color;
        p_bright   <= cfg_bright;
        p_rate     <= cfg_rate;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end

      if (apply) begin
        cur_mode <= p_mode;
        a_color  <= p_color;
        a_bright <= p_bright;
        a_rate   <= p_rate;
        pre      <= '0;
        hue      <= '0;
        env      <= '0;
        env_down <= 1'b0;
        blink_on <= 1'b1;
      end else begin
        pre <= tick ? '0 : pre + RATE_BITS'(1);
        if (tick) begin
          case (cur_mode)
            MODE_HUE: hue <= (hue == HUE_MAX) ? '0 : hue + HW'(1);
            MODE_BREATHE: begin
              // Triangle envelope: each peak and trough is held for one tick only.
              if (!env_down) begin
                if (env == ALL_ONES) begin
                  env_down <= 1'b1;
                  env      <= env - W'(1);
                end else begin
                  env <= env + W'(1);
                end
              end else begin
                if (env == '0) begin
                  env_down <= 1'b0;
                  env      <= W'(1);
                end else begin
                  env <= env - W'(1);
                end
              end
            end
            MODE_BLINK: blink_on <= ~blink_on;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_fx_pwm.sv
// tb/tb_rgb_fx_pwm.sv - self-checking bench for rgb_fx_pwm at W=4 and W=8
module tb_rgb_fx_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        v4 = 1'b0, r4, fs4;
  logic [2:0]  m4 = '0, pwm4, cm4;
  logic [11:0] c4 = '0;
  logic [3:0]  b4 = '0;
  logic [19:0] rt4 = '0;

  logic        v8 = 1'b0, r8, fs8;
  logic [2:0]  m8 = '0, pwm8, cm8;
  logic [23:0] c8 = '0;
  logic [7:0]  b8 = '0;
  logic [19:0] rt8 = '0;

  int checks = 0;
  int errors = 0;

  rgb_fx_pwm #(.W(4), .RATE_BITS(20)) dut4 (
    .clk(clk), .rst(rst), .cfg_valid(v4), .cfg_ready(r4), .cfg_mode(m4),
    .cfg_color(c4), .cfg_bright(b4), .cfg_rate(rt4), .pwm_out(pwm4),
    .frame_strobe(fs4), .cur_mode(cm4)
  );

  rgb_fx_pwm #(.W(8), .RATE_BITS(20)) dut8 (
    .clk(clk), .rst(rst), .cfg_valid(v8), .cfg_ready(r8), .cfg_mode(m8),
    .cfg_color(c8), .cfg_bright(b8), .cfg_rate(rt8), .pwm_out(pwm8),
    .frame_strobe(fs8), .cur_mode(cm8)
  );

  // Reference model for W=4: M=15, frame=16, hue period 96, envelope period 30.
  function automatic int scale(input int v, input int b);
    return (v * (b + 1)) / 16;
  endfunction

  function automatic int hue_chan(input int h, input int ch);
    int s, rp, r, g, b;
    s = h / 16;
    rp = h % 16;
    r = 0; g = 0; b = 0;
    case (s)
      0: begin r = 15;      g = rp;      b = 0;       end
      1: begin r = 15 - rp; g = 15;      b = 0;       end
      2: begin r = 0;       g = 15;      b = rp;      end
      3: begin r = 0;       g = 15 - rp; b = 15;      end
      4: begin r = rp;      g = 0;       b = 15;      end
      default: begin r = 15; g = 0;      b = 15 - rp; end
    endcase
    return (ch == 0) ? r : (ch == 1) ? g : b;
  endfunction

  function automatic int env_of(input int n);
    int p;
    p = n % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  // n = number of animation ticks that have taken effect.
  function automatic int exp_level(input int mode, input logic [11:0] col, input int br,
                                   input int n, input int ch);
    int c;
    c = int'(col[11 - 4*ch -: 4]);
    case (mode)
      1: return scale(c, br);
      2: return scale(hue_chan(n % 96, ch), br);
      3: return scale(c, scale(env_of(n), br));
      4: return ((n % 2) == 0) ? scale(c, br) : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] pattern(input int lvl);
    logic [15:0] v;
    for (int p = 0; p < 16; p++) v[p] = (lvl == 15) || (p < lvl);
    return v;
  endfunction

  // Offers a config to the W=4 instance and returns on the first cycle after it is applied.
  task automatic apply4(input int mode, input logic [11:0] col, input int br, input int rate);
    int guard;
    guard = 0;
    while (r4 !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (r4 !== 1'b1) begin errors++; $display("FAIL apply_ready: cfg_ready=%b required 1", r4); end
    v4 = 1'b1; m4 = 3'(mode); c4 = col; b4 = 4'(br); rt4 = 20'(rate);
    @(negedge clk);
    v4 = 1'b0; m4 = 3'($urandom); c4 = 12'($urandom); b4 = 4'($urandom); rt4 = 20'($urandom);
    guard = 0;
    while (fs4 !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    @(negedge clk);
    checks++;
    if (cm4 !== 3'(mode) || r4 !== 1'b1)
      begin errors++; $display("FAIL apply_mode: cur_mode=%0d ready=%b required %0d 1", cm4, r4, mode); end
  endtask

  task automatic run_frames(input string tag, input int mode, input logic [11:0] col,
                            input int br, input int rate, input int frames,
                            output logic [15:0] lr, output logic [15:0] lg, output logic [15:0] lb);
    logic [15:0] pr, pg, pb, pf, er, eg, eb;
    int n;
    pr = '0; pg = '0; pb = '0; pf = '0;
    apply4(mode, col, br, rate);
    repeat (16) @(negedge clk);
    for (int j = 1; j <= frames; j++) begin
      for (int p = 0; p < 16; p++) begin
        pr[p] = pwm4[2]; pg[p] = pwm4[1]; pb[p] = pwm4[0]; pf[p] = fs4;
        @(negedge clk);
      end
      // The frame's duty was latched at a strobe from state one cycle earlier.
      n = (16 * j - 2) / (rate + 1);
      er = pattern(exp_level(mode, col, br, n, 0));
      eg = pattern(exp_level(mode, col, br, n, 1));
      eb = pattern(exp_level(mode, col, br, n, 2));
      checks++;
      if ({pr, pg, pb, pf} !== {er, eg, eb, 16'h8000}) begin
        errors++;
        $display("FAIL %s frame %0d (mode %0d n %0d): r/g/b/strobe %h/%h/%h/%h required %h/%h/%h/8000",
                 tag, j, mode, n, pr, pg, pb, pf, er, eg, eb);
      end
    end
    lr = pr; lg = pg; lb = pb;
  endtask

  task automatic test_reset();
    logic [47:0] fsv, exp_fs;
    logic [2:0]  pw_or;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm4 !== 3'b000 || r4 !== 1'b1 || cm4 !== 3'd0 || fs4 !== 1'b0)
      begin errors++; $display("FAIL reset4: pwm=%b ready=%b mode=%0d strobe=%b required 000 1 0 0", pwm4, r4, cm4, fs4); end
    checks++;
    if (pwm8 !== 3'b000 || r8 !== 1'b1 || cm8 !== 3'd0 || fs8 !== 1'b0)
      begin errors++; $display("FAIL reset8: pwm=%b ready=%b mode=%0d strobe=%b required 000 1 0 0", pwm8, r8, cm8, fs8); end
    rst = 1'b0;
    pw_or = '0;
    for (int i = 0; i < 48; i++) begin
      fsv[i] = fs4;
      exp_fs[i] = ((i % 16) == 15);
      pw_or = pw_or | pwm4;
      @(negedge clk);
    end
    checks++;
    if (fsv !== exp_fs) begin errors++; $display("FAIL idle_strobe: %h required %h", fsv, exp_fs); end
    checks++;
    if (pw_or !== 3'b000 || cm4 !== 3'd0 || r4 !== 1'b1)
      begin errors++; $display("FAIL idle_state: pwm_or=%b mode=%0d ready=%b required 000 0 1", pw_or, cm4, r4); end
  endtask

  task automatic test_static();
    logic [15:0] lr, lg, lb;
    run_frames("static", 1, 12'hF80, 15, $urandom_range(0, 20), 2, lr, lg, lb);
    checks++;
    if ({lr, lg, lb} !== {16'hFFFF, 16'h00FF, 16'h0000})
      begin errors++; $display("FAIL static_duty: r/g/b %h/%h/%h required ffff/00ff/0000", lr, lg, lb); end
  endtask

  task automatic test_hue();
    logic [15:0] lr, lg, lb;
    run_frames("hue_wrap", 2, 12'h000, 15, 0, 7, lr, lg, lb);
    run_frames("hue_rate2", 2, 12'h000, 15, 2, 4, lr, lg, lb);
    checks++;
    if ({lr, lg, lb} !== {16'h07FF, 16'hFFFF, 16'h0000})
      begin errors++; $display("FAIL hue_sector1: r/g/b %h/%h/%h required 07ff/ffff/0000", lr, lg, lb); end
    run_frames("hue_dim", 2, 12'h000, $urandom_range(0, 14), $urandom_range(0, 9), 4, lr, lg, lb);
  endtask

  task automatic test_breathe();
    logic [15:0] lr, lg, lb;
    run_frames("breathe_r0", 3, 12'hFFF, 15, 0, 4, lr, lg, lb);
    run_frames("breathe_r1", 3, 12'hFFF, 15, 1, 4, lr, lg, lb);
    checks++;
    if (lr !== 16'h0001) begin errors++; $display("FAIL breathe_trough: r %h required 0001", lr); end
    run_frames("breathe_rnd", 3, 12'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), 4, lr, lg, lb);
  endtask

  task automatic test_blink();
    logic [15:0] lr, lg, lb;
    run_frames("blink_r1", 4, 12'hFFF, 15, 1, 4, lr, lg, lb);
    run_frames("blink_rnd", 4, 12'($urandom), $urandom_range(0, 15), $urandom_range(2, 20), 4, lr, lg, lb);
  endtask

  task automatic test_reserved();
    logic [15:0] lr, lg, lb;
    for (int m = 5; m < 8; m++) run_frames("reserved", m, 12'hFFF, 15, 0, 1, lr, lg, lb);
  endtask

  task automatic test_random();
    logic [15:0] lr, lg, lb;
    for (int i = 0; i < 4; i++)
      run_frames("random", $urandom_range(1, 4), 12'($urandom), $urandom_range(0, 15),
                 $urandom_range(0, 20), 3, lr, lg, lb);
  endtask

  task automatic test_back_to_back();
    int guard, lowcnt;
    guard = 0;
    while (fs8 !== 1'b1 && guard < 600) begin @(negedge clk); guard++; end
    checks++;
    if (fs8 !== 1'b1) begin errors++; $display("FAIL b2b_sync: strobe=%b required 1", fs8); end
    repeat (101) @(negedge clk);
    v8 = 1'b1; m8 = 3'd1; c8 = 24'($urandom); b8 = 8'hFF; rt8 = 20'd0;
    @(negedge clk);
    m8 = 3'd3;
    lowcnt = 0; guard = 0;
    while (r8 === 1'b0 && guard < 300) begin
      if (fs8 === 1'b1) begin
        checks++;
        if (cm8 !== 3'd0) begin errors++; $display("FAIL b2b_mode_at_strobe: mode=%0d required 0", cm8); end
      end
      lowcnt++; guard++;
      @(negedge clk);
    end
    v8 = 1'b0;
    checks++;
    if (lowcnt != 155) begin errors++; $display("FAIL b2b_ready_low: %0d cycles required 155", lowcnt); end
    checks++;
    if (cm8 !== 3'd1) begin errors++; $display("FAIL b2b_applied: mode=%0d required 1", cm8); end
    repeat (300) @(negedge clk);
    checks++;
    if (cm8 !== 3'd1 || r8 !== 1'b1)
      begin errors++; $display("FAIL b2b_second_ignored: mode=%0d ready=%b required 1 1", cm8, r8); end
  endtask

  task automatic test_rst_mid();
    logic [2:0] pw_or, cm_or;
    int lvl;
    apply4(4, 12'hFFF, 15, 0);
    repeat (21) @(negedge clk);
    lvl = exp_level(4, 12'hFFF, 15, 14, 0);
    checks++;
    if (pwm4 !== {3{lvl != 0}}) begin errors++; $display("FAIL blink_running: pwm=%b required %b", pwm4, {3{lvl != 0}}); end
    v4 = 1'b1; m4 = 3'd1; c4 = 12'hABC; b4 = 4'd9;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm4 !== 3'b000 || r4 !== 1'b1 || cm4 !== 3'd0)
      begin errors++; $display("FAIL rst_mid: pwm=%b ready=%b mode=%0d required 000 1 0", pwm4, r4, cm4); end
    rst = 1'b0;
    pw_or = '0; cm_or = '0;
    for (int i = 0; i < 48; i++) begin
      pw_or = pw_or | pwm4;
      cm_or = cm_or | cm4;
      @(negedge clk);
    end
    checks++;
    if (pw_or !== 3'b000 || cm_or !== 3'd0)
      begin errors++; $display("FAIL rst_pending_dropped: pwm_or=%b mode_or=%0d required 000 0", pw_or, cm_or); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_hue();
    test_breathe();
    test_blink();
    test_reserved();
    test_random();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
